// File: rtl/packet_filter_fifo.sv
// packet_filter_fifo: store-and-forward packet buffer. Whole packets are
// written first; only packets whose EOP-beat channel equals KEEP_CHANNEL are
// committed and become readable. Rejected, overflowing or aborted packets are
// removed by rewinding the write pointer to the last commit point.
module packet_filter_fifo #(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int DEPTH         = 256,
  parameter int KEEP_CHANNEL  = 1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  // Avalon-ST sink (from classifier)
  input  logic [AST_DWIDTH-1:0]    sink_data,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  input  logic                     sink_sop,
  input  logic                     sink_eop,
  input  logic [((AST_DWIDTH > 8) ? $clog2(AST_DWIDTH/8) : 1)-1:0] sink_empty,
  input  logic [CHANNEL_WIDTH-1:0] sink_channel,
  // Avalon-ST source
  output logic [AST_DWIDTH-1:0]    src_data,
  output logic                     src_valid,
  input  logic                     src_ready,
  output logic                     src_sop,
  output logic                     src_eop,
  output logic [((AST_DWIDTH > 8) ? $clog2(AST_DWIDTH/8) : 1)-1:0] src_empty,
  output logic [CHANNEL_WIDTH-1:0] src_channel,
  // statistics
  output logic [CNT_WIDTH-1:0]     pass_cnt_o,
  output logic [CNT_WIDTH-1:0]     drop_cnt_o
);

  // An 8-bit bus has no meaningful empty field; keep one bit so ports stay legal.
  localparam int EMPTY_WIDTH = (AST_DWIDTH > 8) ? $clog2(AST_DWIDTH/8) : 1;
  localparam int ADDR_W      = $clog2(DEPTH);

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam logic [CHANNEL_WIDTH-1:0] KEEP_CH = CHANNEL_WIDTH'(KEEP_CHANNEL);

  typedef struct packed {
    logic [AST_DWIDTH-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } word_t;

  typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;

  state_t state, state_n;
  ptr_t   wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr, waddr;
  logic   we, accept, full, sop_full, pass_add, rd_issue;
  logic [1:0] drop_add;
  word_t  mem [DEPTH];
  word_t  q;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  assign accept   = sink_valid && sink_ready;
  assign full     = (ptr_t'(wr_ptr - rd_ptr) == DEPTH_P);
  // A new packet always starts at the commit point (any open packet is
  // abandoned), so its space check is taken from there.
  assign sop_full = (ptr_t'(commit_ptr - rd_ptr) == DEPTH_P);

  // Write FSM: decide write, pointer moves and counter increments per beat.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    waddr        = wr_ptr;
    we           = 1'b0;
    pass_add     = 1'b0;
    drop_add     = 2'd0;
    if (accept) begin
      if (sink_sop) begin
        if (state == WRITE) drop_add = 2'd1;   // abort of the open packet
        wr_ptr_n = commit_ptr;
        if (sop_full) begin
          drop_add = drop_add + 2'd1;
          state_n  = sink_eop ? IDLE : DISCARD;
        end else begin
          we       = 1'b1;
          waddr    = commit_ptr;
          wr_ptr_n = commit_ptr + 1'b1;
          state_n  = WRITE;
        end
      end else if (state == WRITE) begin
        if (full) begin
          wr_ptr_n = commit_ptr;
          drop_add = 2'd1;
          state_n  = sink_eop ? IDLE : DISCARD;
        end else begin
          we       = 1'b1;
          waddr    = wr_ptr;
          wr_ptr_n = wr_ptr + 1'b1;
        end
      end else if (state == DISCARD && sink_eop) begin
        state_n = IDLE;
      end
      // Keep/drop decision on a written EOP beat.
      if (we && sink_eop) begin
        state_n = IDLE;
        if (sink_channel == KEEP_CH) begin
          commit_ptr_n = waddr + 1'b1;
          pass_add     = 1'b1;
        end else begin
          wr_ptr_n = commit_ptr;
          drop_add = drop_add + 2'd1;
        end
      end
    end
  end

  // Write-side state, pointers, counters and the always-ready sink.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pass_cnt_o <= '0;
      drop_cnt_o <= '0;
      sink_ready <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      pass_cnt_o <= sat_add(pass_cnt_o, {1'b0, pass_add});
      drop_cnt_o <= sat_add(drop_cnt_o, drop_add);
      sink_ready <= 1'b1;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr[ADDR_W-1:0]] <= '{sink_data, sink_sop, sink_eop, sink_empty};
  end

  // Only committed beats are readable; read when the output register is
  // empty or draining this cycle, so back-to-back beats stream at full rate.
  assign rd_issue = (rd_ptr != commit_ptr) && (!src_valid || src_ready);

  // Read pointer plus the synchronous RAM read register that drives src.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_ptr    <= '0;
      q         <= '0;
      src_valid <= 1'b0;
    end else if (rd_issue) begin
      rd_ptr    <= rd_ptr + 1'b1;
      q         <= mem[rd_ptr[ADDR_W-1:0]];
      src_valid <= 1'b1;
    end else if (src_ready) begin
      src_valid <= 1'b0;
    end
  end

  assign src_data    = q.data;
  assign src_sop     = q.sop;
  assign src_eop     = q.eop;
  assign src_empty   = q.empty;
  assign src_channel = src_valid ? KEEP_CH : '0;

endmodule
